// File: rtl/axi_lite_bus_arbiter_pkg.sv
// Shared state encoding and AXI response codes for the IFU/LSU AXI4-Lite arbiter.
// Declarations only: no latency, no backpressure.
package axi_lite_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        WR1  = 2'd3
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_rd_mux.sv
// Combinational 2:1 AR/R channel mux; sel=1 routes m1, sel=0 routes m0, en=0 idles everything.
// Zero latency; readies/valids pass straight through, so backpressure is the far side's.
module axi_lite_rd_mux
    import axi_lite_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              en,
    input  logic              sel,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready
);

    always_comb begin
        s_araddr   = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = RESP_OKAY;
        m0_rvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = RESP_OKAY;
        m1_rvalid  = 1'b0;
        if (en) begin
            if (sel) begin
                s_araddr   = m1_araddr;
                s_arvalid  = m1_arvalid;
                s_rready   = m1_rready;
                m1_arready = s_arready;
                m1_rdata   = s_rdata;
                m1_rresp   = s_rresp;
                m1_rvalid  = s_rvalid;
            end else begin
                s_araddr   = m0_araddr;
                s_arvalid  = m0_arvalid;
                s_rready   = m0_rready;
                m0_arready = s_arready;
                m0_rdata   = s_rdata;
                m0_rresp   = s_rresp;
                m0_rvalid  = s_rvalid;
            end
        end
    end

endmodule

// File: rtl/axi_lite_bus_arbiter.sv
// Shares one AXI4-Lite slave between IFU (m0, read) and LSU (m1, read/write), one transaction at a time;
// grant one cycle after request, held until the response handshake; ARB_RR_EN selects round-robin reads.
module axi_lite_bus_arbiter
    import axi_lite_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic [1:0]          m1_bresp,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rvalid,
    output logic                s_rready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic [1:0]          s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready,
    output logic                busy
);

    arb_state_t state_q, state_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    arb_state_t tie_rd;
    logic       wr_act;

`ifdef ARB_RR_EN
    logic last_rd_q;  // 1 = m1 got the last read grant
    assign tie_rd = last_rd_q ? RD0 : RD1;
`else
    assign tie_rd = RD1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_rd_q <= 1'b1;
        end else if (state_q == IDLE && (state_d == RD0 || state_d == RD1)) begin
            last_rd_q <= (state_d == RD1);
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (m1_awvalid)                    state_d = WR1;
                else if (m1_arvalid && m0_arvalid) state_d = tie_rd;
                else if (m1_arvalid)               state_d = RD1;
                else if (m0_arvalid)               state_d = RD0;
            end
            RD0, RD1: begin
                if (s_rvalid && s_rready) state_d = IDLE;
            end
            WR1: begin
                if (s_awvalid && s_awready) aw_done_d = 1'b1;
                if (s_wvalid && s_wready)   w_done_d  = 1'b1;
                // B ends the write even if the slave answered early
                if (s_bvalid && s_bready) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    axi_lite_rd_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rd_mux (
        .en         (state_q == RD0 || state_q == RD1),
        .sel        (state_q == RD1),
        .m0_araddr  (m0_araddr),
        .m0_arvalid (m0_arvalid),
        .m0_arready (m0_arready),
        .m0_rdata   (m0_rdata),
        .m0_rresp   (m0_rresp),
        .m0_rvalid  (m0_rvalid),
        .m0_rready  (m0_rready),
        .m1_araddr  (m1_araddr),
        .m1_arvalid (m1_arvalid),
        .m1_arready (m1_arready),
        .m1_rdata   (m1_rdata),
        .m1_rresp   (m1_rresp),
        .m1_rvalid  (m1_rvalid),
        .m1_rready  (m1_rready),
        .s_araddr   (s_araddr),
        .s_arvalid  (s_arvalid),
        .s_arready  (s_arready),
        .s_rdata    (s_rdata),
        .s_rresp    (s_rresp),
        .s_rvalid   (s_rvalid),
        .s_rready   (s_rready)
    );

    assign wr_act     = (state_q == WR1);
    assign s_awaddr   = wr_act ? m1_awaddr : '0;
    assign s_awvalid  = wr_act && !aw_done_q && m1_awvalid;
    assign m1_awready = wr_act && !aw_done_q && s_awready;
    assign s_wdata    = wr_act ? m1_wdata : '0;
    assign s_wstrb    = wr_act ? m1_wstrb : '0;
    assign s_wvalid   = wr_act && !w_done_q && m1_wvalid;
    assign m1_wready  = wr_act && !w_done_q && s_wready;
    assign s_bready   = wr_act && m1_bready;
    assign m1_bvalid  = wr_act && s_bvalid;
    assign m1_bresp   = wr_act ? s_bresp : RESP_OKAY;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_axi_lite_bus_arbiter.sv
// Directed bench for axi_lite_bus_arbiter: reactive slave model, master driver tasks, queue scoreboard.
// Expectations are pushed at issue time; a negedge monitor pops and compares on every handshake.
module tb_axi_lite_bus_arbiter;
    import axi_lite_bus_arbiter_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] m0_araddr, m1_araddr, m1_awaddr, m1_wdata;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp, m1_bresp;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic [3:0]  m1_wstrb, s_wstrb;
    logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
    logic [1:0]  s_rresp, s_bresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int proto_viol = 0;
    int ar_dly = 0, r_dly = 1, aw_dly = 0, w_dly = 0, b_dly = 1;

    logic [32:0] exp_slv[$];   // {is_write, addr} in slave-side order
    logic [35:0] exp_w[$];
    logic [33:0] exp_r0[$];
    logic [33:0] exp_r1[$];
    logic [1:0]  exp_b[$];

    axi_lite_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .busy(busy)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic no_exp(input string name);
        tests++;
        fails++;
        $display("FAIL %s: handshake seen with nothing expected", name);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [12:0] ctl_vec();
        return {busy, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready,
                m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid};
    endfunction

    function automatic logic [31:0] slave_rdata(input logic [31:0] a);
        case (a)
            32'h8000_0000: return 32'h0000_0413;
            32'h8000_0004: return 32'h00A0_0093;
            32'h8000_1000: return 32'h1234_5678;
            32'h9000_0000: return 32'hBAD0_0000;
            default:       return a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    // Slave model: samples handshakes at negedge, reacts just after the next posedge.
    initial begin
        int acnt, awc, wc, rwait, bwait;
        bit rd_pend, aw_got, w_got, ar_hs, r_hs, aw_hs, w_hs, b_hs;
        logic [31:0] raddr, ar_smp;
        acnt = 0; awc = 0; wc = 0; rwait = 0; bwait = 0;
        rd_pend = 0; aw_got = 0; w_got = 0; raddr = '0;
        s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0;
        forever begin
            @(negedge clock);
            ar_hs  = s_arvalid && s_arready;
            r_hs   = s_rvalid && s_rready;
            aw_hs  = s_awvalid && s_awready;
            w_hs   = s_wvalid && s_wready;
            b_hs   = s_bvalid && s_bready;
            ar_smp = s_araddr;
            @(posedge clock);
            #1;
            if (!reset) begin
                acnt = 0; awc = 0; wc = 0; bwait = 0;
                rd_pend = 0; aw_got = 0; w_got = 0;
                s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
                s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0;
            end else begin
                if (ar_hs) begin
                    s_arready = 0; acnt = 0; rd_pend = 1; rwait = r_dly; raddr = ar_smp;
                end else if (rd_pend) begin
                    if (rwait <= 1) begin
                        s_rvalid = 1;
                        s_rdata  = slave_rdata(raddr);
                        s_rresp  = (raddr == 32'h9000_0000) ? RESP_SLVERR : RESP_OKAY;
                        rd_pend  = 0;
                    end else rwait--;
                end else if (r_hs) begin
                    s_rvalid = 0; s_rdata = '0; s_rresp = '0;
                end else if (s_arvalid && !s_arready && !s_rvalid) begin
                    if (acnt >= ar_dly) s_arready = 1;
                    else acnt++;
                end
                if (aw_hs) begin
                    s_awready = 0; aw_got = 1; awc = 0;
                end else if (s_awvalid && !s_awready && !aw_got) begin
                    if (awc >= aw_dly) s_awready = 1;
                    else awc++;
                end
                if (w_hs) begin
                    s_wready = 0; w_got = 1; wc = 0;
                end else if (s_wvalid && !s_wready && !w_got) begin
                    if (wc >= w_dly) s_wready = 1;
                    else wc++;
                end
                if (b_hs) begin
                    s_bvalid = 0; aw_got = 0; w_got = 0; bwait = 0;
                end else if (aw_got && w_got && !s_bvalid) begin
                    if (bwait >= b_dly) begin
                        s_bvalid = 1; s_bresp = RESP_OKAY;
                    end else bwait++;
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        bit w_seen, aw_seen, after_hs;
        w_seen = 0; aw_seen = 0; after_hs = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                w_seen = 0; aw_seen = 0; after_hs = 0;
            end else begin
                if (after_hs) check("busy_after_resp", {63'd0, busy}, 64'd0);
                after_hs = 0;
                if (s_arvalid && (s_awvalid || s_wvalid || s_bready)) proto_viol++;
                if (s_rready && s_bready) proto_viol++;
                if (s_wvalid && w_seen) proto_viol++;
                if (s_awvalid && aw_seen) proto_viol++;
                if (s_arvalid && s_arready) begin
                    if (exp_slv.size() == 0) no_exp("slv_ar");
                    else check("slv_ar_order", {31'd0, 1'b0, s_araddr}, {31'd0, exp_slv.pop_front()});
                end
                if (s_awvalid && s_awready) begin
                    aw_seen = 1;
                    if (exp_slv.size() == 0) no_exp("slv_aw");
                    else check("slv_aw_order", {31'd0, 1'b1, s_awaddr}, {31'd0, exp_slv.pop_front()});
                end
                if (s_wvalid && s_wready) begin
                    w_seen = 1;
                    if (exp_w.size() == 0) no_exp("slv_w");
                    else check("slv_w_data", {28'd0, s_wdata, s_wstrb}, {28'd0, exp_w.pop_front()});
                end
                if (m0_rvalid && m0_rready) begin
                    after_hs = 1;
                    if (exp_r0.size() == 0) no_exp("m0_r");
                    else check("m0_r_data", {30'd0, m0_rdata, m0_rresp}, {30'd0, exp_r0.pop_front()});
                end
                if (m1_rvalid && m1_rready) begin
                    after_hs = 1;
                    if (exp_r1.size() == 0) no_exp("m1_r");
                    else check("m1_r_data", {30'd0, m1_rdata, m1_rresp}, {30'd0, exp_r1.pop_front()});
                end
                if (m1_bvalid && m1_bready) begin
                    after_hs = 1; w_seen = 0; aw_seen = 0;
                    if (exp_b.size() == 0) no_exp("m1_b");
                    else check("m1_b_resp", {62'd0, m1_bresp}, {62'd0, exp_b.pop_front()});
                end
            end
        end
    end

    task automatic m0_rd(input logic [31:0] a);
        int n; bit hs;
        n = 0; hs = 0;
        m0_araddr = a; m0_arvalid = 1;
        while (!hs && n < 100) begin
            @(negedge clock); hs = m0_arvalid && m0_arready;
            @(posedge clock); #1; n++;
        end
        m0_arvalid = 0; m0_araddr = '0;
        if (!hs) no_exp("m0_ar_timeout");
    endtask

    task automatic m1_rd(input logic [31:0] a);
        int n; bit hs;
        n = 0; hs = 0;
        m1_araddr = a; m1_arvalid = 1;
        while (!hs && n < 100) begin
            @(negedge clock); hs = m1_arvalid && m1_arready;
            @(posedge clock); #1; n++;
        end
        m1_arvalid = 0; m1_araddr = '0;
        if (!hs) no_exp("m1_ar_timeout");
    endtask

    task automatic m1_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        fork
            begin
                int n; bit hs;
                n = 0; hs = 0;
                m1_awaddr = a; m1_awvalid = 1;
                while (!hs && n < 100) begin
                    @(negedge clock); hs = m1_awvalid && m1_awready;
                    @(posedge clock); #1; n++;
                end
                m1_awvalid = 0; m1_awaddr = '0;
                if (!hs) no_exp("m1_aw_timeout");
            end
            begin
                int n; bit hs;
                n = 0; hs = 0;
                m1_wdata = d; m1_wstrb = s; m1_wvalid = 1;
                while (!hs && n < 100) begin
                    @(negedge clock); hs = m1_wvalid && m1_wready;
                    @(posedge clock); #1; n++;
                end
                m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0;
                if (!hs) no_exp("m1_w_timeout");
            end
        join
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (n < 300) begin
            @(negedge clock);
            if (!busy && exp_slv.size() == 0 && exp_w.size() == 0 && exp_r0.size() == 0 &&
                exp_r1.size() == 0 && exp_b.size() == 0) break;
            n++;
        end
        if (n >= 300) begin
            tests++; fails++;
            $display("FAIL %s: arbiter did not drain within 300 cycles", name);
        end
        @(posedge clock); #1;
    endtask

    task automatic tie_reads(input string name);
`ifdef ARB_RR_EN
        exp_slv.push_back({1'b0, 32'h8000_0004});
        exp_slv.push_back({1'b0, 32'h8000_1000});
`else
        exp_slv.push_back({1'b0, 32'h8000_1000});
        exp_slv.push_back({1'b0, 32'h8000_0004});
`endif
        exp_r0.push_back({32'h00A0_0093, RESP_OKAY});
        exp_r1.push_back({32'h1234_5678, RESP_OKAY});
        fork
            m0_rd(32'h8000_0004);
            m1_rd(32'h8000_1000);
        join
        wait_idle(name);
    endtask

    initial begin
        reset = 0;
        m0_araddr = '0; m0_arvalid = 0; m0_rready = 1;
        m1_araddr = '0; m1_arvalid = 0; m1_rready = 1;
        m1_awaddr = '0; m1_awvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 0; m1_bready = 1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_ctl", {51'd0, ctl_vec()}, 64'd0);
        check("reset_addr", {32'd0, s_araddr}, 64'd0);
        step(1);
        reset = 1;
        step(1);

        tie_reads("tie_first");
        tie_reads("tie_repeat");

        // lone m0 read: grant one cycle after request
        ar_dly = 1; r_dly = 2;
        exp_slv.push_back({1'b0, 32'h8000_0000});
        exp_r0.push_back({32'h0000_0413, RESP_OKAY});
        fork
            m0_rd(32'h8000_0000);
            begin
                @(negedge clock); check("s_arvalid_req_cycle", {63'd0, s_arvalid}, 64'd0);
                @(negedge clock); check("s_arvalid_next_cycle", {63'd0, s_arvalid}, 64'd1);
            end
        join
        wait_idle("m0_alone");
        ar_dly = 0; r_dly = 1;

        // write with W accepted before AW, m0 read pending throughout
        aw_dly = 3; w_dly = 1;
        exp_slv.push_back({1'b1, 32'h1000_0000});
        exp_slv.push_back({1'b0, 32'h8000_0000});
        exp_w.push_back({32'h0000_0041, 4'b0001});
        exp_b.push_back(RESP_OKAY);
        exp_r0.push_back({32'h0000_0413, RESP_OKAY});
        fork
            m1_wr(32'h1000_0000, 32'h0000_0041, 4'b0001);
            begin step(1); m0_rd(32'h8000_0000); end
        join
        wait_idle("write_then_m0");
        aw_dly = 0; w_dly = 0;

        // m1 write and m1 read raised together: write first
        exp_slv.push_back({1'b1, 32'h1000_0004});
        exp_slv.push_back({1'b0, 32'h8000_1000});
        exp_w.push_back({32'hDEAD_BEEF, 4'b1111});
        exp_b.push_back(RESP_OKAY);
        exp_r1.push_back({32'h1234_5678, RESP_OKAY});
        fork
            m1_wr(32'h1000_0004, 32'hDEAD_BEEF, 4'b1111);
            m1_rd(32'h8000_1000);
        join
        wait_idle("aw_ar_together");

        // SLVERR passes through unchanged
        exp_slv.push_back({1'b0, 32'h9000_0000});
        exp_r1.push_back({32'hBAD0_0000, RESP_SLVERR});
        m1_rd(32'h9000_0000);
        wait_idle("m1_slverr");
        check("slverr_idle_busy", {63'd0, busy}, 64'd0);

        // reset between AR and R of an m1 read
        r_dly = 8;
        exp_slv.push_back({1'b0, 32'h8000_1000});
        m1_rd(32'h8000_1000);
        @(negedge clock);
        check("midrd_busy_before", {63'd0, busy}, 64'd1);
        #2 reset = 0;
        #1 check("midrd_reset_ctl", {51'd0, ctl_vec()}, 64'd0);
        step(2);
        reset = 1;
        r_dly = 1;
        step(1);
        exp_slv.push_back({1'b0, 32'h8000_0000});
        exp_r0.push_back({32'h0000_0413, RESP_OKAY});
        m0_rd(32'h8000_0000);
        wait_idle("post_reset_m0");

        check("protocol_violations", 64'(proto_viol), 64'd0);
        check("queues_empty", 64'(exp_slv.size() + exp_w.size() + exp_r0.size() + exp_r1.size() + exp_b.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_lite_bus_arbiter.md
Name: axi_lite_bus_arbiter

Overview:
- Shares one AXI4-Lite slave port (memory/MMIO crossbar) between two masters.
- m0 is the IFU, read-only. m1 is the LSU, read and write.
- Grants exactly one transaction at a time and holds the grant until that transaction's response handshake completes.
- Sits between the IFU/LSU AXI masters and the SoC bus. All routing is combinational from a registered grant state.

Parameters:
- ADDR_W, 32, address width on all AR/AW channels.
- DATA_W, 32, data width on R/W channels; strobe width is DATA_W/8.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- m0_araddr/m0_arvalid/m0_arready  in/in/out  ADDR_W/1/1  IFU read-address channel.
- m0_rdata/m0_rresp/m0_rvalid/m0_rready  out/out/out/in  DATA_W/2/1/1  IFU read-data channel.
- m1_araddr/m1_arvalid/m1_arready  in/in/out  ADDR_W/1/1  LSU read-address channel.
- m1_rdata/m1_rresp/m1_rvalid/m1_rready  out/out/out/in  DATA_W/2/1/1  LSU read-data channel.
- m1_awaddr/m1_awvalid/m1_awready  in/in/out  ADDR_W/1/1  LSU write-address channel.
- m1_wdata/m1_wstrb/m1_wvalid/m1_wready  in/in/in/out  DATA_W/DATA_W/8/1/1  LSU write-data channel.
- m1_bresp/m1_bvalid/m1_bready  out/out/in  2/1/1  LSU write-response channel.
- s_araddr/s_arvalid/s_arready  out/out/in  ADDR_W/1/1  slave read-address channel.
- s_rdata/s_rresp/s_rvalid/s_rready  in/in/in/out  DATA_W/2/1/1  slave read-data channel.
- s_awaddr/s_awvalid/s_awready  out/out/in  ADDR_W/1/1  slave write-address channel.
- s_wdata/s_wstrb/s_wvalid/s_wready  out/out/out/in  DATA_W/DATA_W/8/1/1  slave write-data channel.
- s_bresp/s_bvalid/s_bready  in/in/out  2/1/1  slave write-response channel.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- State machine (registered): IDLE, RD0 (m0 read), RD1 (m1 read), WR1 (m1 write). Registered flags aw_done and w_done; last_rd (RR mode only).
- Reset (reset=0, asynchronous): state=IDLE, aw_done=w_done=0, last_rd=m1.
  - All outputs are decoded from state, so all valid/ready outputs are 0 and busy=0 while reset is held.
  - Data/address/resp outputs are don't-care but driven 0 in IDLE.
- IDLE: no slave valids, no master readies.
  - Choose on the clock edge where any request is pending.
  - Fixed priority: m1_awvalid > m1_arvalid > m0_arvalid.
  - Next cycle is the granted state. Minimum one cycle from request to slave valid.
- RD0/RD1: the granted master's AR/R channels are wired straight to s_AR/s_R.
  - Non-granted masters see arready=0, rvalid=0, rdata/rresp=0.
  - s_aw/s_w valids are 0.
  - Exit to IDLE on the edge where s_rvalid && s_rready. The next grant is possible one cycle later.
- WR1: m1 AW and W are forwarded independently; order between them is free.
  - aw_done sets on s_awvalid&&s_awready. After that, s_awvalid is forced 0 and m1_awready=0.
  - w_done sets the same way for the W channel.
  - s_bready=m1_bready; m1_bvalid=s_bvalid; m1_bresp=s_bresp.
  - Exit to IDLE on the B handshake and clear both flags.
  - A B handshake arriving before both flags are set is a slave protocol violation; the arbiter still exits.
- A valid from a non-granted master is held pending, never dropped. AXI rule: a master keeps valid until ready.
- A master lowering valid before its grant takes effect has no effect. The transaction was simply not yet issued; the slave never sees valid.
- Simultaneous R handshake and a new request: the request is evaluated in IDLE next cycle.
- Reset mid-transaction: immediate abort. The slave may be left with an orphan response, which the SoC reset clears too.
- No buffering; combinational paths run master↔slave through a mux only.

Optional Feature:
- ARB_RR_EN defined: reads use round-robin between m0 and m1.
  - When both arvalids are high in IDLE, grant the master not equal to last_rd.
  - last_rd updates on each read grant.
  - Writes still win over all reads.
- Undefined: fixed priority as above; the last_rd register is absent.

Decomposition:
- Shared package (or include file) holds:
  - state encoding localparams (IDLE=0, RD0=1, RD1=2, WR1=3);
  - AXI resp codes OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
- Natural sub-module: axi_lite_rd_mux, a combinational 2:1 AR/R channel mux selected by a grant bit. Write path stays inline; it has only one source.

Test Plan:
- m0 read 0x8000_0000 alone, slave arready 1 cycle later and rdata 0x0000_0413 2 cycles later → s_arvalid rises one cycle after m0_arvalid; m0_rdata=0x0000_0413 with rvalid; busy falls the cycle after the R handshake.
- m0 and m1 arvalid in the same cycle, addrs 0x8000_0004/0x8000_1000 → fixed mode: m1 served first, m0 next. With ARB_RR_EN after reset: m0 served first, then m1; a repeated tie alternates.
- m1 write 0x1000_0000, wdata 0x41, wstrb 0001; slave gives wready 2 cycles before awready → s_wvalid drops after its handshake, aw completes later; one B with OKAY reaches m1; m0 pending arvalid is granted only after B.
- m1 awvalid and m1 arvalid together → write granted first, read afterwards; no overlap of s_arvalid and s_awvalid.
- Assert reset=0 in the middle of RD1 (after AR handshake, before R) → same cycle: all valids/readies 0, busy=0; after release, a new m0 request is granted normally.
- Slave returns rresp=SLVERR on an m1 read → m1_rresp=2'b10 passed unchanged; arbiter returns to IDLE.
